// File: rtl/fp_add_arb.sv
// Round-robin arbiter sharing one fp_add among NUM_REQ requesters; a tag pipeline routes each sum back.
// Latency: transfer to rsp_vld is ADD_LATENCY+2 cycles. No adder backpressure; en low stops new grants only.
// Optional issue counter on busy_cnt is built when FP_ADD_ARB_STATS_EN is defined.
module fp_add_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_vld,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_rdy,
    output logic                   add_in_vld,
    output logic [31:0]            add_a,
    output logic [31:0]            add_b,
    input  logic                   add_sum_vld,
    input  logic [31:0]            add_sum,
    output logic [NUM_REQ-1:0]     rsp_vld,
    output logic [31:0]            rsp_sum,
    output logic                   idle,
    output logic                   err_orphan,
    output logic [31:0]            busy_cnt
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          gnt_idx;
    logic [IW-1:0]          add_idx;
    logic [CW-1:0]          cand;
    logic                   gnt_any;
    logic                   xfer;
    logic                   pending;
    logic [ADD_LATENCY-1:0] tag_vld;
    logic [IW-1:0]          tag_idx [ADD_LATENCY];

    // Search from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = CW'(rr_ptr) + CW'(k + 1);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!gnt_any && req_vld[cand[IW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (state == RUN && !rst && gnt_any) begin
            req_rdy[gnt_idx] = 1'b1;
        end
    end

    assign xfer    = |(req_vld & req_rdy);
    // The issue register counts as in flight so DRAIN cannot exit before its tag is loaded.
    assign pending = add_in_vld | (|tag_vld);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle      = 1'b0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (en) state_nxt = RUN;
            end
            RUN: begin
                if (!en) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (en)            state_nxt = RUN;
                else if (!pending) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= IW'(NUM_REQ - 1);
            add_in_vld <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_idx    <= '0;
            tag_vld    <= '0;
            for (int i = 0; i < ADD_LATENCY; i++) begin
                tag_idx[i] <= '0;
            end
            rsp_vld    <= '0;
            rsp_sum    <= '0;
            err_orphan <= 1'b0;
        end else begin
            add_in_vld <= xfer;
            if (xfer) begin
                rr_ptr  <= gnt_idx;
                add_idx <= gnt_idx;
                add_a   <= req_a[32*gnt_idx +: 32];
                add_b   <= req_b[32*gnt_idx +: 32];
            end
            tag_vld[0] <= add_in_vld;
            tag_idx[0] <= add_idx;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
            rsp_vld <= '0;
            if (add_sum_vld && tag_vld[ADD_LATENCY-1]) begin
                rsp_vld[tag_idx[ADD_LATENCY-1]] <= 1'b1;
                rsp_sum                         <= add_sum;
            end
            // A result without a tag (or a tag without a result) means the two pipelines lost sync.
            if (add_sum_vld != tag_vld[ADD_LATENCY-1]) begin
                err_orphan <= 1'b1;
            end
        end
    end

`ifdef FP_ADD_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if (add_in_vld) begin
            busy_cnt <= busy_cnt + 32'd1;
        end
    end
`else
    assign busy_cnt = '0;
`endif

endmodule
